// File: rtl/rx_deserialiser_pkg.sv
// Shared constants, deserialiser state encoding and bit-insert helper for the
// ISO14443A receive path.
package ISO14443A_pkg;

  localparam int BITS_PER_BYTE = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RECEIVING = 3'd1,
    ST_FLUSH     = 3'd2,
    ST_DONE      = 3'd3,
    ST_DROPPING  = 3'd4
  } deser_state_e;

  function automatic logic [7:0] set_bit(input logic [7:0] v, input logic [2:0] idx,
                                         input logic b);
    logic [7:0] r;
    r      = v;
    r[idx] = b;
    return r;
  endfunction

endpackage

// File: rtl/rx_deserialiser_if.sv
// Frame stream interface: bit-wide (BY_BYTE=0) from frame_decode or byte-wide
// (BY_BYTE=1) towards the protocol layer.
interface rx_interface #(parameter int BY_BYTE = 0);

  localparam int DW = (BY_BYTE != 0) ? 8 : 1;

  logic          soc;
  logic          eoc;
  logic          error;
  logic          data_valid;
  logic [DW-1:0] data;
  logic [2:0]    data_bits;

  modport master (output soc, eoc, error, data_valid, data, data_bits);
  // data_bits carries no meaning on the bit-wide side, so receivers leave it out.
  modport slave  (input  soc, eoc, error, data_valid, data);

endinterface

// File: rtl/rx_deserialiser.sv
// Bit-to-byte deserialiser with frame framing/error handling.
// Optional RX_DESERIALISER_BYTE_COUNT_EN adds a per-frame byte_count output.
module rx_deserialiser
  import ISO14443A_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  rx_interface.slave  in_iface,
  rx_interface.master out_iface
`ifdef RX_DESERIALISER_BYTE_COUNT_EN
  ,
  output logic [8:0]  byte_count
`endif
);

  deser_state_e r_state;
  logic [7:0]   r_shift;
  logic [2:0]   r_cnt;
  logic         r_soc;
  logic         r_eoc;
  logic         r_error;
  logic         r_dv;
  logic [7:0]   r_data;
  logic [2:0]   r_bits;

  logic [7:0]   w_shift_upd;
  logic [2:0]   w_cnt_upd;
  logic         w_full;

  // Shift/count as they stand once this cycle's bit (if any) is taken in.
  always_comb begin
    w_shift_upd = r_shift;
    w_cnt_upd   = r_cnt;
    w_full      = 1'b0;
    if (in_iface.data_valid) begin
      w_shift_upd = set_bit(r_shift, r_cnt, in_iface.data[0]);
      w_cnt_upd   = r_cnt + 3'd1;
      w_full      = (r_cnt == 3'(BITS_PER_BYTE - 1));
    end else begin
      w_full      = 1'b0;
    end
  end

  // Frame FSM with registered outputs; soc overrides everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= 8'h00;
      r_cnt   <= 3'd0;
      r_soc   <= 1'b0;
      r_eoc   <= 1'b0;
      r_error <= 1'b0;
      r_dv    <= 1'b0;
      r_data  <= 8'h00;
      r_bits  <= 3'd0;
    end else begin
      r_soc   <= 1'b0;
      r_error <= 1'b0;
      r_dv    <= 1'b0;
      if (in_iface.soc) begin
        r_soc   <= 1'b1;
        r_eoc   <= 1'b0;
        r_shift <= 8'h00;
        r_cnt   <= 3'd0;
        r_state <= ST_RECEIVING;
      end else begin
        case (r_state)
          ST_RECEIVING: begin
            if (in_iface.error) begin
              r_error <= 1'b1;
              r_shift <= 8'h00;
              r_cnt   <= 3'd0;
              if (in_iface.eoc) begin
                r_eoc   <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_state <= ST_DROPPING;
              end
            end else begin
              // Upper bits of a partial byte stay 0 because the shift clears per byte.
              r_cnt   <= w_cnt_upd;
              r_shift <= w_full ? 8'h00 : w_shift_upd;
              if (w_full) begin
                r_dv   <= 1'b1;
                r_data <= w_shift_upd;
                r_bits <= 3'd0;
              end
              if (in_iface.eoc) begin
                if (w_cnt_upd == 3'd0) begin
                  r_eoc   <= 1'b1;
                  r_state <= ST_DONE;
                end else begin
                  r_dv    <= 1'b1;
                  r_data  <= w_shift_upd;
                  r_bits  <= w_cnt_upd;
                  r_state <= ST_FLUSH;
                end
              end
            end
          end
          ST_FLUSH: begin
            r_eoc   <= 1'b1;
            r_state <= ST_DONE;
          end
          ST_DROPPING: begin
            if (in_iface.eoc) begin
              r_eoc   <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_DROPPING;
            end
          end
          ST_IDLE, ST_DONE: r_state <= r_state;
          default:          r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign out_iface.soc        = r_soc;
  assign out_iface.eoc        = r_eoc;
  assign out_iface.error      = r_error;
  assign out_iface.data_valid = r_dv;
  assign out_iface.data       = r_data;
  assign out_iface.data_bits  = r_bits;

`ifdef RX_DESERIALISER_BYTE_COUNT_EN
  logic w_emit;

  // A byte (full or partial) will be emitted on the next edge.
  always_comb begin
    w_emit = 1'b0;
    if ((r_state == ST_RECEIVING) && !in_iface.error) begin
      w_emit = w_full || (in_iface.eoc && (w_cnt_upd != 3'd0));
    end else begin
      w_emit = 1'b0;
    end
  end

  // Saturating per-frame byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_count <= 9'd0;
    end else if (in_iface.soc) begin
      byte_count <= 9'd0;
    end else if (w_emit && (byte_count != 9'd511)) begin
      byte_count <= byte_count + 9'd1;
    end else begin
      byte_count <= byte_count;
    end
  end
`endif

endmodule

// File: tb/tb_rx_deserialiser.sv
// Scoreboard bench for rx_deserialiser: a frame-level model predicts output events
// with their cycle; a negedge monitor pops and compares whatever the DUT emits.
module tb_rx_deserialiser;

  localparam int K_SOC  = 0;
  localparam int K_BYTE = 1;
  localparam int K_ERR  = 2;
  localparam int K_EOC  = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic [2:0] bits;
    int         cyc;
    int         bc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_interface #(.BY_BYTE(0)) in_if ();
  rx_interface #(.BY_BYTE(1)) out_if ();
`ifdef RX_DESERIALISER_BYTE_COUNT_EN
  logic [8:0] byte_count;
`endif

  rx_deserialiser dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_iface  (in_if),
    .out_iface (out_if)
`ifdef RX_DESERIALISER_BYTE_COUNT_EN
    ,
    .byte_count(byte_count)
`endif
  );

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame-level reference: mode 0 idle, 1 receiving, 2 partial flushed, 3 dropping, 4 done
  int m_mode = 0;
  bit m_bits[$];
  int m_bc = 0;

  function automatic void push_ev(int k, logic [7:0] d, logic [2:0] b, int c);
    ev_t e;
    e.kind = k; e.data = d; e.bits = b; e.cyc = c; e.bc = m_bc;
    q.push_back(e);
  endfunction

  function automatic logic [7:0] packed_bits();
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < m_bits.size(); i++) v[i] = m_bits[i];
    return v;
  endfunction

  function automatic void emit_byte(logic [2:0] b, int c);
    if (m_bc < 511) m_bc = m_bc + 1;
    push_ev(K_BYTE, packed_bits(), b, c);
    m_bits.delete();
  endfunction

  function automatic void model(bit s, bit e, bit er, bit v, bit d, int c);
    if (m_mode == 2 && !s) begin
      push_ev(K_EOC, 8'h00, 3'd0, c);
      m_mode = 4;
    end
    if (s) begin
      m_bits.delete();
      m_bc = 0;
      push_ev(K_SOC, 8'h00, 3'd0, c);
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (er) begin
        push_ev(K_ERR, 8'h00, 3'd0, c);
        m_bits.delete();
        if (e) begin
          push_ev(K_EOC, 8'h00, 3'd0, c);
          m_mode = 4;
        end else begin
          m_mode = 3;
        end
      end else begin
        if (v) m_bits.push_back(d);
        if (m_bits.size() == 8) emit_byte(3'd0, c);
        if (e) begin
          if (m_bits.size() == 0) begin
            push_ev(K_EOC, 8'h00, 3'd0, c);
            m_mode = 4;
          end else begin
            emit_byte(3'(m_bits.size()), c);
            m_mode = 2;
          end
        end
      end
    end else if (m_mode == 3 && e) begin
      push_ev(K_EOC, 8'h00, 3'd0, c);
      m_mode = 4;
    end
  endfunction

  task automatic drive(input bit s, input bit e, input bit er, input bit v, input bit d);
    in_if.soc = s; in_if.eoc = e; in_if.error = er; in_if.data_valid = v; in_if.data[0] = d;
    model(s, e, er, v, d, cyc + 1);
    @(posedge clk); #1;
    in_if.soc = 1'b0; in_if.eoc = 1'b0; in_if.error = 1'b0; in_if.data_valid = 1'b0;
    in_if.data[0] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, b[i]);
  endtask

  task automatic check_zero(input string name);
    logic [19:0] act;
    act = {out_if.soc, out_if.eoc, out_if.error, out_if.data_valid, out_if.data, out_if.data_bits,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (act != 20'd0) begin
      errors++;
      $display("FAIL %s outputs=%h required 0", name, act);
    end
`ifdef RX_DESERIALISER_BYTE_COUNT_EN
    checks++;
    if (byte_count != 9'd0) begin
      errors++;
      $display("FAIL %s byte_count=%0d required 0", name, byte_count);
    end
`endif
  endtask

  task automatic expect_ev(input int k, input logic [7:0] d, input logic [2:0] b);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d cycle=%0d data=%h bits=%0d, required none",
               k, cyc, d, b);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.cyc != cyc || (k == K_BYTE && (e.data != d || e.bits != b))) begin
        errors++;
        $display("FAIL event got kind=%0d cyc=%0d data=%h bits=%0d, required kind=%0d cyc=%0d data=%h bits=%0d",
                 k, cyc, d, b, e.kind, e.cyc, e.data, e.bits);
      end
`ifdef RX_DESERIALISER_BYTE_COUNT_EN
      if (k == K_EOC) begin
        checks++;
        if (byte_count != 9'(e.bc)) begin
          errors++;
          $display("FAIL byte_count got %0d required %0d", byte_count, e.bc);
        end
      end
`endif
    end
  endtask

  // Monitor: sample outputs mid-cycle and retire scoreboard entries.
  bit prev_eoc = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_eoc = 1'b0;
    end else begin
      if (out_if.soc)        expect_ev(K_SOC, 8'h00, 3'd0);
      if (out_if.data_valid) expect_ev(K_BYTE, out_if.data, out_if.data_bits);
      if (out_if.error)      expect_ev(K_ERR, 8'h00, 3'd0);
      if (out_if.eoc && !prev_eoc) expect_ev(K_EOC, 8'h00, 3'd0);
      if (!out_if.eoc && prev_eoc) begin
        checks++;
        if (!out_if.soc) begin
          errors++;
          $display("FAIL eoc_hold eoc fell at cycle %0d without soc, required held", cyc);
        end
      end
      prev_eoc = out_if.eoc;
    end
  end

  initial begin
    int n;
    bit abort_f, err_f, join_f;
    int err_at;
    in_if.soc = 1'b0; in_if.eoc = 1'b0; in_if.error = 1'b0; in_if.data_valid = 1'b0;
    in_if.data = 1'b0; in_if.data_bits = 3'd0;
    #2 check_zero("reset_state");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // 0xA5 full byte, then ignored noise in DONE
    drive(1, 0, 0, 0, 0); send_byte(8'hA5); drive(0, 1, 0, 0, 0);
    idle(3); drive(0, 0, 1, 1, 1); drive(0, 1, 0, 1, 0); idle(2);
    // partial 1,0,1
    drive(1, 0, 0, 0, 0); drive(0, 0, 0, 1, 1); drive(0, 0, 0, 1, 0); drive(0, 0, 0, 1, 1);
    drive(0, 1, 0, 0, 0); idle(3);
    // 0x3C, 4 bits, error, junk in DROPPING, eoc
    drive(1, 0, 0, 0, 0); send_byte(8'h3C);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 1'(i));
    drive(0, 0, 1, 0, 0); drive(0, 0, 1, 1, 1); drive(0, 1, 0, 0, 0); idle(3);
    // aborted frame then 0xFF, soc with simultaneous eoc/dv
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 1);
    drive(1, 1, 1, 1, 1); send_byte(8'hFF); drive(0, 1, 0, 0, 0); idle(3);
    // empty frame
    drive(1, 0, 0, 0, 0); drive(0, 1, 0, 0, 0); idle(3);
    // last bit and eoc together
    drive(1, 0, 0, 0, 0); for (int i = 0; i < 7; i++) drive(0, 0, 0, 1, 1'(i));
    drive(0, 1, 0, 1, 1); idle(3);

    // reset mid-frame
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, 1);
    rst_n = 1'b0;
    #1 check_zero("reset_midframe");
    m_mode = 0; m_bits.delete(); m_bc = 0;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_at_reset count=%0d required 0", q.size());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 1); drive(0, 1, 1, 1, 0); idle(2);
    drive(1, 0, 0, 0, 0); send_byte(8'h81); drive(0, 1, 0, 0, 0); idle(3);

    // random frames
    for (int f = 0; f < 60; f++) begin
      n = $urandom_range(0, 20);
      abort_f = ($urandom_range(0, 7) == 0);
      err_f = ($urandom_range(0, 5) == 0);
      err_at = $urandom_range(0, 20);
      join_f = $urandom_range(0, 1) == 1;
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        if (err_f && i == err_at) drive(0, 0, 1, $urandom_range(0, 1) == 1, 0);
        else if (!abort_f && join_f && i == n - 1) drive(0, 1, 0, 1, $urandom_range(0, 1) == 1);
        else drive(0, 0, 0, 1, $urandom_range(0, 1) == 1);
      end
      if (!abort_f && !(join_f && n > 0 && !(err_f && err_at == n - 1))) drive(0, 1, 0, 0, 0);
      for (int i = 0; i < $urandom_range(0, 2); i++)
        drive(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    idle(5);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events count=%0d required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_deserialiser.md
RX_DESERIALISER -- requirements
Module: rx_deserialiser

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  13.56 MHz system clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_iface.soc  input  1  one-cycle start-of-frame pulse from frame_decode.
REQ-005 in_iface.eoc  input  1  end-of-frame; rises once per frame.
REQ-006 in_iface.error  input  1  one-cycle error pulse (parity/coding).
REQ-007 in_iface.data_valid  input  1  qualifies in_iface.data.
REQ-008 in_iface.data  input  1  received bit, LSB of each byte first.
REQ-009 out_iface.soc  output  1  registered start-of-frame pulse.
REQ-010 out_iface.eoc  output  1  end-of-frame level, held until next soc.
REQ-011 out_iface.error  output  1  registered error pulse.
REQ-012 out_iface.data_valid  output  1  one-cycle pulse qualifying data/data_bits.
REQ-013 out_iface.data  output  8  assembled byte; bit i = i-th received bit.
REQ-014 out_iface.data_bits  output  3  valid bits in data; 0 means all 8.

Function
REQ-015 States: IDLE, RECEIVING, FLUSH, DONE, DROPPING.
REQ-016 in soc in any state: out soc pulses the next cycle; shift register and 3-bit bit counter clear; out eoc clears; state becomes RECEIVING.
REQ-017 soc has priority: data_valid, eoc or error in the same cycle are ignored.
REQ-018 RECEIVING, data_valid: bit is written to position bit_count; bit_count increments modulo 8.
REQ-019 On the 8th bit: out data_valid pulses the next cycle with the byte and data_bits=0. Latency is 1 cycle from last-bit data_valid to output.
REQ-020 RECEIVING, eoc with bit_count==0: out eoc rises the next cycle; state becomes DONE.
REQ-021 RECEIVING, eoc with bit_count=N (1..7): out data_valid pulses the next cycle with data_bits=N and unused upper bits 0; state becomes FLUSH.
REQ-022 FLUSH: out eoc rises one cycle after the partial-byte data_valid; state becomes DONE.
REQ-023 data_valid and eoc in the same cycle: the bit is counted first, then the REQ-020/021 rules apply to the updated count.
REQ-024 RECEIVING, error: out error pulses the next cycle; partial bits are discarded; state becomes DROPPING.
REQ-025 DROPPING ignores data_valid and error; eoc raises out eoc the next cycle and moves to DONE without emitting a partial byte.
REQ-026 IDLE and DONE ignore data_valid, error and eoc.
REQ-027 soc mid-frame (RECEIVING, FLUSH or DROPPING) aborts the frame: pending bits are discarded and no eoc is emitted for the aborted frame.
REQ-028 Outside its pulse, out data holds its last value; out data_valid, soc and error never exceed one cycle.

Reset
REQ-029 Asserting rst_n low forces IDLE, bit_count=0, shift register=0, and every output to 0, including out eoc and data_bits.
REQ-030 Reset mid-frame discards the frame; no output activity until the next in soc.

Configuration
REQ-031 Macro RX_DESERIALISER_BYTE_COUNT_EN adds output byte_count[8:0]: number of out data_valid pulses in the current frame, including partial bytes.
REQ-032 With the macro, byte_count clears on in soc and on reset, saturates at 511, and holds after eoc.
REQ-033 Without the macro, the port and its counter are absent; all other behaviour is identical.

Structure
REQ-034 ISO14443A_pkg holds BITS_PER_BYTE=8 and the deserialiser state enum typedef.
REQ-035 Single module with no sub-modules; ports use rx_interface instances (BY_BYTE=0 on input, BY_BYTE=1 on output).

Verification
REQ-036 soc, bits of 0xA5 (LSB first), eoc -> one data_valid with data=0xA5, data_bits=0; eoc rises 1 cycle later; eoc held until next soc.
REQ-037 soc, 3 bits 1,0,1, eoc -> data_valid with data=0x05, data_bits=3; eoc exactly 1 cycle after it.
REQ-038 soc, 0x3C, then error after 4 more bits, then eoc -> one byte 0x3C, one error pulse, no partial byte, eoc asserted.
REQ-039 soc, 5 bits, soc, 0xFF, eoc -> no output for the aborted 5 bits; one byte 0xFF, data_bits=0; two soc pulses.
REQ-040 soc, eoc with zero bits -> no data_valid; soc then eoc; with RX_DESERIALISER_BYTE_COUNT_EN, byte_count=0.
REQ-041 rst_n pulsed low after 6 bits -> all outputs 0 immediately; a following frame of 0x81 decodes correctly.
